// File: rtl/cpu_addr_seq_pkg.sv
// rtl/cpu_addr_seq_pkg.sv - shared FSM encodings and default sizes for the CPU address sequencer
package cpu_addr_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_NUM_BANKS  = 24;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DEPTH      = 256;
  localparam int DEF_LEN_W      = 9;

endpackage

// File: rtl/cpu_addr_lane.sv
// rtl/cpu_addr_lane.sv - one bank address pointer with load / advance / hold, wrapping at DEPTH
module cpu_addr_lane
  import cpu_addr_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  rotated,
  input  logic [ADDR_WIDTH-1:0] ofs,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] ptr
);

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST      = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] load_val;

  assign load_val = (rotated && ({1'b0, ofs} < DEPTH_EXT)) ? ofs : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else if (advance) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_addr_seq.sv
// rtl/cpu_addr_seq.sv - burst address sequencer driving NUM_BANKS lanes with valid/ready beats
module cpu_addr_seq
  import cpu_addr_seq_pkg::*;
#(
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LEN_W      = DEF_LEN_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            abort,
  input  logic                            mode,
  input  logic [LEN_W-1:0]                burst_len,
  input  logic [NUM_BANKS*ADDR_WIDTH-1:0] bank_ofs,
  input  logic                            addr_rdy,
  output logic                            addr_vld,
  output logic [NUM_BANKS*ADDR_WIDTH-1:0] cpu_addr,
  output logic [LEN_W-1:0]                beat_idx,
  output logic                            busy,
  output logic                            done
);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic             accept;
  logic             xfer;

  assign accept = (state == ST_IDLE) && start && !abort;
  // An aborted beat is not counted, so pointers and beat_idx stay consistent.
  assign xfer   = addr_vld && addr_rdy && !abort;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_lane
      cpu_addr_lane #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH)
      ) u_lane (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .rotated(mode),
        .ofs    (bank_ofs[gi*ADDR_WIDTH +: ADDR_WIDTH]),
        .advance(xfer),
        .ptr    (cpu_addr[gi*ADDR_WIDTH +: ADDR_WIDTH])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      len_q    <= '0;
      beat_idx <= '0;
      addr_vld <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (abort) begin
      state    <= ST_IDLE;
      addr_vld <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            len_q    <= burst_len;
            beat_idx <= '0;
            busy     <= 1'b1;
            if (burst_len != '0) begin
              state    <= ST_RUN;
              addr_vld <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (xfer) begin
            beat_idx <= beat_idx + 1'b1;
            if (beat_idx == len_q - 1'b1) begin
              state    <= ST_DONE;
              addr_vld <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          addr_vld <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule
